trigger_sequencer: RTL and testbench

//  Per-channel trigger controller that drives the framing stage (header/footer insertion) of one ADC channel.

---
 rtl/krd_trigger_pkg.sv | 14 +
 rtl/hit_detector.sv | 45 ++++
 rtl/trigger_sequencer.sv | 173 +++++++++++++++++
 tb/tb_trigger_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/krd_trigger_pkg.sv
// Shared definitions for the per-channel trigger sequencer.
//   SAMPLE_LANE_WIDTH : width of one sample lane inside an ADC word
//   trig_state_t      : trigger FSM state encoding (IDLE / ACTIVE / HOLDOFF)
package krd_trigger_pkg;

  localparam int SAMPLE_LANE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_t;

endpackage

// File: rtl/hit_detector.sv
// Combinational threshold-crossing detector for one ADC word.
// Each 16-bit lane carries an unsigned sample in its low ADC_RESOLUTION_WIDTH
// bits. The lane is a hit when (sample - BASELINE), taken as a signed value
// one bit wider than the sample, is strictly greater than the signed THRESHOLD.
// Ports:
//   DIN_VALID : DIN holds a valid word this cycle
//   DIN       : packed sample lanes
//   THRESHOLD : signed offset above baseline (live value)
//   BASELINE  : unsigned baseline (live value)
//   word_hit  : DIN_VALID and at least one lane hit
module hit_detector
  import krd_trigger_pkg::*;
#(
  parameter int DATA_WIDTH           = 128,
  parameter int ADC_RESOLUTION_WIDTH = 12
) (
  input  logic                            DIN_VALID,
  input  logic [DATA_WIDTH-1:0]           DIN,
  input  logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
  output logic                            word_hit
);

  localparam int NUM_LANES = DATA_WIDTH / SAMPLE_LANE_WIDTH;

  logic [NUM_LANES-1:0] lane_hit;
  logic                 unused_din;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [ADC_RESOLUTION_WIDTH-1:0] sample;
    logic [ADC_RESOLUTION_WIDTH:0]   diff;

    assign sample      = DIN[i*SAMPLE_LANE_WIDTH +: ADC_RESOLUTION_WIDTH];
    // Both operands are zero-extended, so the difference always fits the
    // extra sign bit and can never wrap.
    assign diff        = {1'b0, sample} - {1'b0, BASELINE};
    assign lane_hit[i] = $signed(diff) > $signed(THRESHOLD);
  end

  assign word_hit = DIN_VALID & (|lane_hit);

  // The upper bits of every lane carry no sample data.
  assign unused_din = ^DIN;

endmodule

// File: rtl/trigger_sequencer.sv
// Per-channel trigger controller feeding the header/footer framing stage.
// Opens a frame on a threshold crossing, closes it after POST_TRIGGER_WORDS
// consecutive valid non-hit words or MAX_FRAME_WORDS valid words, then holds
// TRIGGERED low for HOLDOFF_CYCLES clocks so the framer can insert a footer
// and the next header. The threshold/baseline in force at frame start are
// frozen for the footer. All outputs are registered.
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   ENABLE              : allows new frames to start (does not abort a frame)
//   DIN_VALID, DIN      : ADC word stream
//   THRESHOLD, BASELINE : live compare settings
//   TRIGGERED           : high while a frame is open (one cycle after the hit word)
//   THRESHOLD_WHEN_HIT  : THRESHOLD captured at frame start
//   BASELINE_WHEN_HIT   : BASELINE captured at frame start
//   TRUNCATED           : one-cycle pulse when a frame closes on length limit
//   BUSY                : FSM in ACTIVE or HOLDOFF
//   FRAME_COUNT         : frames started since reset, wrapping
module trigger_sequencer
  import krd_trigger_pkg::*;
#(
  parameter int DATA_WIDTH           = 128,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int POST_TRIGGER_WORDS   = 4,
  parameter int MAX_FRAME_WORDS      = 64,
  parameter int HOLDOFF_CYCLES       = 4,
  parameter int FRAME_CNT_WIDTH      = 16
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            ENABLE,
  input  logic                            DIN_VALID,
  input  logic [DATA_WIDTH-1:0]           DIN,
  input  logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
  output logic                            TRIGGERED,
  output logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD_WHEN_HIT,
  output logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE_WHEN_HIT,
  output logic                            TRUNCATED,
  output logic                            BUSY,
  output logic [FRAME_CNT_WIDTH-1:0]      FRAME_COUNT
);

  localparam int LEN_W  = $clog2(MAX_FRAME_WORDS + 1);
  localparam int POST_W = $clog2(POST_TRIGGER_WORDS + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_FRAME_WORDS);
  localparam logic [POST_W-1:0] POST_MAX  = POST_W'(POST_TRIGGER_WORDS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  trig_state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q,  len_d,  len_inc;
  logic [POST_W-1:0] post_q, post_d, post_inc;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic triggered_q, triggered_d;
  logic truncated_q, truncated_d;
  logic busy_q;
  logic start_frame;
  logic word_hit;

  logic [ADC_RESOLUTION_WIDTH:0]   thr_hit_q;
  logic [ADC_RESOLUTION_WIDTH-1:0] base_hit_q;
  logic [FRAME_CNT_WIDTH-1:0]      frame_count_q;

  hit_detector #(
    .DATA_WIDTH           (DATA_WIDTH),
    .ADC_RESOLUTION_WIDTH (ADC_RESOLUTION_WIDTH)
  ) u_hit_detector (
    .DIN_VALID (DIN_VALID),
    .DIN       (DIN),
    .THRESHOLD (THRESHOLD),
    .BASELINE  (BASELINE),
    .word_hit  (word_hit)
  );

  // Counter values that the current valid word would produce.
  assign len_inc  = len_q + LEN_W'(1);
  assign post_inc = word_hit ? '0 : post_q + POST_W'(1);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    post_d      = post_q;
    hold_d      = hold_q;
    triggered_d = triggered_q;
    truncated_d = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (word_hit && ENABLE) begin
          state_d     = ACTIVE;
          len_d       = LEN_W'(1);
          post_d      = '0;
          triggered_d = 1'b1;
          start_frame = 1'b1;
        end
      end

      ACTIVE: begin
        // Words with DIN_VALID low leave both counters untouched.
        if (DIN_VALID) begin
          len_d  = len_inc;
          post_d = post_inc;
          if ((len_inc == LEN_MAX) || (post_inc == POST_MAX)) begin
            state_d     = HOLDOFF;
            hold_d      = '0;
            triggered_d = 1'b0;
            // A simultaneous post-trigger close still reports truncation.
            truncated_d = (len_inc == LEN_MAX);
          end
        end
      end

      HOLDOFF: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        triggered_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      len_q         <= '0;
      post_q        <= '0;
      hold_q        <= '0;
      triggered_q   <= 1'b0;
      truncated_q   <= 1'b0;
      busy_q        <= 1'b0;
      thr_hit_q     <= '0;
      base_hit_q    <= '0;
      frame_count_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      post_q      <= post_d;
      hold_q      <= hold_d;
      triggered_q <= triggered_d;
      truncated_q <= truncated_d;
      busy_q      <= (state_d != IDLE);
      // The captured pair stays put through HOLDOFF and IDLE so the footer
      // reads stable values until the next frame starts.
      if (start_frame) begin
        thr_hit_q     <= THRESHOLD;
        base_hit_q    <= BASELINE;
        frame_count_q <= frame_count_q + FRAME_CNT_WIDTH'(1);
      end
    end
  end

  assign TRIGGERED          = triggered_q;
  assign TRUNCATED          = truncated_q;
  assign BUSY               = busy_q;
  assign THRESHOLD_WHEN_HIT = thr_hit_q;
  assign BASELINE_WHEN_HIT  = base_hit_q;
  assign FRAME_COUNT        = frame_count_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer with default parameters, plus a second
// instance with a 4-bit frame counter so counter wrap is reachable quickly.
module tb_trigger_sequencer;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          ENABLE;
  logic          DIN_VALID;
  logic [127:0]  DIN;
  logic [12:0]   THRESHOLD;
  logic [11:0]   BASELINE;

  logic          TRIGGERED;
  logic [12:0]   THRESHOLD_WHEN_HIT;
  logic [11:0]   BASELINE_WHEN_HIT;
  logic          TRUNCATED;
  logic          BUSY;
  logic [15:0]   FRAME_COUNT;

  logic          w4_triggered;
  logic [12:0]   w4_thr_hit;
  logic [11:0]   w4_base_hit;
  logic          w4_truncated;
  logic          w4_busy;
  logic [3:0]    w4_frame_count;

  int n_checks = 0;
  int n_pass   = 0;
  int hi_cnt;
  int trunc_cnt;

  always #5 CLK = ~CLK;

  trigger_sequencer u_dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .ENABLE             (ENABLE),
    .DIN_VALID          (DIN_VALID),
    .DIN                (DIN),
    .THRESHOLD          (THRESHOLD),
    .BASELINE           (BASELINE),
    .TRIGGERED          (TRIGGERED),
    .THRESHOLD_WHEN_HIT (THRESHOLD_WHEN_HIT),
    .BASELINE_WHEN_HIT  (BASELINE_WHEN_HIT),
    .TRUNCATED          (TRUNCATED),
    .BUSY               (BUSY),
    .FRAME_COUNT        (FRAME_COUNT)
  );

  trigger_sequencer #(.FRAME_CNT_WIDTH(4)) u_dut_w4 (
    .CLK                (CLK),
    .RESET              (RESET),
    .ENABLE             (ENABLE),
    .DIN_VALID          (DIN_VALID),
    .DIN                (DIN),
    .THRESHOLD          (THRESHOLD),
    .BASELINE           (BASELINE),
    .TRIGGERED          (w4_triggered),
    .THRESHOLD_WHEN_HIT (w4_thr_hit),
    .BASELINE_WHEN_HIT  (w4_base_hit),
    .TRUNCATED          (w4_truncated),
    .BUSY               (w4_busy),
    .FRAME_COUNT        (w4_frame_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge and new
  // inputs are applied at the same point, well before the next edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one word: lane 3 carries the sample, lane 7 has only its unused
  // upper bits set (must never cause a hit), all other lanes are zero.
  task automatic drive(input logic valid, input logic [11:0] sample);
    logic [127:0] w;
    w           = '0;
    w[48 +: 12] = sample;
    w[124 +: 4] = 4'hF;
    DIN         = w;
    DIN_VALID   = valid;
    tick();
  endtask

  initial begin
    RESET     = 1'b1;
    ENABLE    = 1'b1;
    DIN_VALID = 1'b0;
    DIN       = '0;
    THRESHOLD = 13'd50;
    BASELINE  = 12'd100;

    // ---- reset state
    tick();
    tick();
    check("rst_triggered", TRIGGERED, 0);
    check("rst_truncated", TRUNCATED, 0);
    check("rst_busy", BUSY, 0);
    check("rst_frame_count", FRAME_COUNT, 0);
    check("rst_thr_hit", THRESHOLD_WHEN_HIT, 0);
    check("rst_base_hit", BASELINE_WHEN_HIT, 0);
    RESET = 1'b0;

    // ---- threshold boundary: 150-100=50 is not above 50, 151 is
    drive(1'b1, 12'd150);
    check("no_hit_at_equal", TRIGGERED, 0);
    check("no_hit_busy", BUSY, 0);
    drive(1'b1, 12'd151);
    check("hit_triggered", TRIGGERED, 1);
    check("hit_busy", BUSY, 1);
    check("hit_frame_count", FRAME_COUNT, 1);
    check("hit_thr_latched", THRESHOLD_WHEN_HIT, 50);
    check("hit_base_latched", BASELINE_WHEN_HIT, 100);

    // ---- post-trigger close after 4 non-hit words
    hi_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'd0);
      if (TRIGGERED) hi_cnt++;
    end
    check("post_high_cycles", hi_cnt, 4);
    check("post_closed", TRIGGERED, 0);
    check("post_not_truncated", TRUNCATED, 0);
    check("post_busy_holdoff", BUSY, 1);

    // ---- hits during holdoff are ignored; restart right after
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'd200);
      if (TRIGGERED) hi_cnt++;
    end
    check("holdoff_ignored", hi_cnt, 0);
    check("holdoff_count", FRAME_COUNT, 1);
    check("holdoff_done_busy", BUSY, 0);
    drive(1'b1, 12'd200);
    check("restart_triggered", TRIGGERED, 1);
    check("restart_frame_count", FRAME_COUNT, 2);

    // ---- continuous hits: 64-word frame, truncated
    hi_cnt    = 1;
    trunc_cnt = 0;
    for (int i = 0; i < 63; i++) begin
      drive(1'b1, 12'd200);
      if (TRIGGERED) hi_cnt++;
      if (TRUNCATED) trunc_cnt++;
    end
    check("trunc_high_cycles", hi_cnt, 63);
    check("trunc_closed", TRIGGERED, 0);
    check("trunc_pulse", TRUNCATED, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12'd200);
      if (TRIGGERED) hi_cnt++;
      if (TRUNCATED) trunc_cnt++;
    end
    check("trunc_pulse_count", trunc_cnt, 1);
    check("trunc_holdoff_low", hi_cnt, 63);
    drive(1'b1, 12'd200);
    check("trunc_restart", TRIGGERED, 1);
    check("trunc_restart_count", FRAME_COUNT, 3);

    // ---- gaps, live threshold change, ENABLE drop mid-frame
    drive(1'b1, 12'd0);                       // post 1
    drive(1'b1, 12'd0);                       // post 2
    THRESHOLD = 13'd10;
    for (int i = 0; i < 3; i++) drive(1'b0, 12'd200);
    check("gap_still_open", TRIGGERED, 1);
    drive(1'b1, 12'd111);                     // 11 > 10: hit under live threshold
    check("live_thr_hit_open", TRIGGERED, 1);
    drive(1'b1, 12'd0);                       // post 1
    ENABLE = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 12'd0);
    drive(1'b1, 12'd0);                       // post 2
    drive(1'b1, 12'd0);                       // post 3
    check("gap_post3_open", TRIGGERED, 1);
    check("gap_thr_frozen", THRESHOLD_WHEN_HIT, 50);
    drive(1'b1, 12'd0);                       // post 4
    check("gap_closed", TRIGGERED, 0);
    check("gap_not_truncated", TRUNCATED, 0);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 12'd200);
      if (TRIGGERED) hi_cnt++;
      if (i == 2) check("holdoff_thr_stable", THRESHOLD_WHEN_HIT, 50);
    end
    check("disabled_no_restart", hi_cnt, 0);
    check("disabled_count", FRAME_COUNT, 3);
    check("disabled_thr_stable", THRESHOLD_WHEN_HIT, 50);
    check("disabled_busy", BUSY, 0);

    // ---- reset mid-ACTIVE
    ENABLE = 1'b1;
    drive(1'b1, 12'd200);
    check("pre_reset_triggered", TRIGGERED, 1);
    check("pre_reset_count", FRAME_COUNT, 4);
    check("pre_reset_thr", THRESHOLD_WHEN_HIT, 10);
    RESET = 1'b1;
    drive(1'b1, 12'd200);
    check("mid_rst_triggered", TRIGGERED, 0);
    check("mid_rst_truncated", TRUNCATED, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_count", FRAME_COUNT, 0);
    check("mid_rst_thr", THRESHOLD_WHEN_HIT, 0);
    check("mid_rst_base", BASELINE_WHEN_HIT, 0);
    RESET = 1'b0;

    // ---- frame counter wrap (4-bit instance wraps 0xF -> 0x0)
    for (int f = 0; f < 16; f++) begin
      drive(1'b1, 12'd200);
      for (int i = 0; i < 4; i++) drive(1'b1, 12'd0);
      for (int i = 0; i < 4; i++) drive(1'b0, 12'd0);
      if (f == 14) begin
        check("wrap_w4_max", w4_frame_count, 4'hF);
        check("wrap_main_15", FRAME_COUNT, 15);
      end
    end
    check("wrap_w4_zero", w4_frame_count, 0);
    check("wrap_main_16", FRAME_COUNT, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
